add_seq_ks: RTL and testbench



---
 rtl/add_seq_ks_pkg.sv | 20 ++
 rtl/add_seq_ks_if.sv | 49 ++++
 rtl/add4_ks.sv | 32 +++
 rtl/add_seq_ks_ci.sv | 33 +++
 rtl/add_seq_ks.sv | 115 +++++++++++
 tb/tb_add_seq_ks.sv | 260 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/add_seq_ks_pkg.sv
// rtl/add_seq_ks_pkg.sv - shared types, constants and sizing helper for the nibble-serial adder
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateE;

  localparam int NIBBLE_W = 4;

  // Slice index width; never below one bit so a single-nibble build still has an idx register.
  function automatic int idxWidth(input int nibbles);
    int w;
    w = 1;
    while ((1 << w) < nibbles) w++;
    return w;
  endfunction

endpackage

// File: rtl/add_seq_ks_if.sv
// rtl/add_seq_ks_if.sv - operand/result handshake bundle; in_sub only exists with ADD_SEQ_SUB_EN
interface add_seq_ks_if #(
  parameter int NIBBLES = 4
);
  import add_seq_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
`ifdef ADD_SEQ_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_co;

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
`ifdef ADD_SEQ_SUB_EN
    output in_sub,
`endif
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_co
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
`ifdef ADD_SEQ_SUB_EN
    input  in_sub,
`endif
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_co
  );

endinterface

// File: rtl/add4_ks.sv
// rtl/add4_ks.sv - 4-bit Kogge-Stone adder, no carry-in
module add4_ks (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g0, p0, g1, g2;
  logic [3:2] p1;

  assign g0 = a & b;
  assign p0 = a ^ b;

  // Prefix level 1: span 2
  assign g1[0] = g0[0];
  assign g1[1] = g0[1] | (p0[1] & g0[0]);
  assign g1[2] = g0[2] | (p0[2] & g0[1]);
  assign g1[3] = g0[3] | (p0[3] & g0[2]);
  assign p1[2] = p0[2] & p0[1];
  assign p1[3] = p0[3] & p0[2];

  // Prefix level 2: span 4, g2[i] is the carry out of bit i
  assign g2[0] = g1[0];
  assign g2[1] = g1[1];
  assign g2[2] = g1[2] | (p1[2] & g1[0]);
  assign g2[3] = g1[3] | (p1[3] & g1[1]);

  assign s  = p0 ^ {g2[2:0], 1'b0};
  assign co = g2[3];

endmodule

// File: rtl/add_seq_ks_ci.sv
// rtl/add_seq_ks_ci.sv - add4_ci: 4-bit adder with carry-in built from two add4_ks stages
module add4_ci (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] pS;
  logic [3:0] qS;
  logic       pCo;
  logic       qCo;

  add4_ks uStageP (
    .a  (a),
    .b  (b),
    .s  (pS),
    .co (pCo)
  );

  add4_ks uStageQ (
    .a  (pS),
    .b  ({3'b000, ci}),
    .s  (qS),
    .co (qCo)
  );

  // Adding ci to pS can only carry when pS is all ones, which implies pCo was 0.
  assign s  = qS;
  assign co = pCo | qCo;

endmodule

// File: rtl/add_seq_ks.sv
// rtl/add_seq_ks.sv - nibble-serial wide adder sequencer; ADD_SEQ_SUB_EN adds A-B via in_sub
module add_seq_ks #(
  parameter int NIBBLES = 4
) (
  input logic         clk,
  input logic         rst,
  add_seq_ks_if.slave bus
);
  import add_seq_pkg::*;

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idxWidth(NIBBLES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic [W-1:0]     aReg;
  logic [W-1:0]     bReg;
  logic [W-1:0]     sumReg;
  logic [IDX_W-1:0] idx;
  logic             cy;
  logic             subSel;

  logic [3:0] aSlice;
  logic [3:0] bSlice;
  logic [3:0] bOperand;
  logic [3:0] sliceSum;
  logic       sliceCo;

`ifdef ADD_SEQ_SUB_EN
  logic subReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      subReg <= 1'b0;
    end else if (state == ST_IDLE && bus.in_valid) begin
      subReg <= bus.in_sub;
    end
  end

  assign subSel = subReg;
`else
  assign subSel = 1'b0;
`endif

  assign aSlice   = 4'(aReg >> {idx, 2'b00});
  assign bSlice   = 4'(bReg >> {idx, 2'b00});
  assign bOperand = subSel ? ~bSlice : bSlice;

  add4_ci uSlice (
    .a  (aSlice),
    .b  (bOperand),
    .ci (cy),
    .s  (sliceSum),
    .co (sliceCo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      aReg   <= '0;
      bReg   <= '0;
      sumReg <= '0;
      idx    <= '0;
      cy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            aReg   <= bus.in_a;
            bReg   <= bus.in_b;
            sumReg <= '0;
            idx    <= '0;
`ifdef ADD_SEQ_SUB_EN
            cy     <= bus.in_sub;
`else
            cy     <= 1'b0;
`endif
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
              sumReg[NIBBLE_W*i +: NIBBLE_W] <= sliceSum;
            end
          end
          cy <= sliceCo;
          if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // cy is frozen once in DONE, so it doubles as the result carry-out.
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_sum   = sumReg;
  assign bus.out_co    = cy;

endmodule

// File: tb/tb_add_seq_ks.sv
// tb/tb_add_seq_ks.sv - directed-vector bench for add_seq_ks (subtract vectors with ADD_SEQ_SUB_EN)
module tb_add_seq_ks;

  logic clk;
  logic rst;
  int   vecCount;
  int   errCount;

  add_seq_ks_if #(.NIBBLES(4)) bus ();

  add_seq_ks #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation from an IDLE cycle (called #1 after an edge) and returns what was seen.
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output logic [15:0] s, output logic c, output int lat);
    lat = -1;
    bus.in_a      = a;
    bus.in_b      = b;
`ifdef ADD_SEQ_SUB_EN
    bus.in_sub    = sub;
`else
    if (sub) $display("note: subtract requested without ADD_SEQ_SUB_EN");
`endif
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'hDEAD;
    bus.in_b      = 16'hBEEF;
    for (int k = 1; k <= 20; k++) begin
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    s = bus.out_sum;
    c = bus.out_co;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecCount++;
    if (bus.in_ready !== 1'b1) begin
      errCount++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    vecCount++;
    if (bus.out_valid !== 1'b0) begin
      errCount++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    vecCount++;
    if (bus.out_sum !== 16'h0000 || bus.out_co !== 1'b0) begin
      errCount++;
      $display("FAIL reset_result: got sum %h co %b want sum 0000 co 0", bus.out_sum, bus.out_co);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    logic [15:0] va[5];
    logic [15:0] vb[5];
    logic [15:0] es[5];
    logic        ec[5];
    logic [15:0] s;
    logic        c;
    int          lat;
    va = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0FFF, 16'hABCD};
    vb = '{16'h4321, 16'h0001, 16'h8000, 16'h0001, 16'h1111};
    es = '{16'h5555, 16'h0000, 16'h0000, 16'h1000, 16'hBCDE};
    ec = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    for (int i = 0; i < 5; i++) begin
      runOp(va[i], vb[i], 1'b0, s, c, lat);
      vecCount++;
      if (lat !== 5) begin
        errCount++;
        $display("FAIL add_latency[%0d]: got %0d cycles want 5", i, lat);
      end
      vecCount++;
      if (s !== es[i] || c !== ec[i]) begin
        errCount++;
        $display("FAIL add_result[%0d] %h+%h: got %h co %b want %h co %b",
                 i, va[i], vb[i], s, c, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int seen;
    seen = 0;
    bus.in_a      = 16'h00FF;
    bus.in_b      = 16'h0F01;
`ifdef ADD_SEQ_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      if (bus.out_valid) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    vecCount++;
    if (seen != 1) begin
      errCount++;
      $display("FAIL bp_timeout: out_valid %b want 1 within 20 cycles", bus.out_valid);
    end
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = k[0] ? 1'b0 : 1'b1;
      bus.in_a     = 16'hFFFF;
      bus.in_b     = 16'hFFFF;
      @(posedge clk); #1;
      vecCount++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_sum !== 16'h1000 || bus.out_co !== 1'b0) begin
        errCount++;
        $display("FAIL bp_hold[%0d]: got valid %b ready %b sum %h co %b want 1 0 1000 0",
                 k, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_co);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    vecCount++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errCount++;
      $display("FAIL bp_release: got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    vecCount++;
    if (bus.in_ready !== 1'b1) begin
      errCount++;
      $display("FAIL bp_no_ghost_op: got in_ready %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] s;
    logic        c;
    int          lat;
    int          rose;
    rose = 0;
    bus.in_a      = 16'h1234;
    bus.in_b      = 16'h1111;
`ifdef ADD_SEQ_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vecCount++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_sum !== 16'h0000 || bus.out_co !== 1'b0) begin
      errCount++;
      $display("FAIL midrun_reset: got ready %b valid %b sum %h co %b want 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.out_sum, bus.out_co);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) rose = 1;
    end
    vecCount++;
    if (rose != 0) begin
      errCount++;
      $display("FAIL midrun_no_result: got out_valid rise %0d want 0", rose);
    end
    runOp(16'h0001, 16'h0001, 1'b0, s, c, lat);
    vecCount++;
    if (s !== 16'h0002 || c !== 1'b0 || lat !== 5) begin
      errCount++;
      $display("FAIL midrun_followup: got %h co %b lat %0d want 0002 co 0 lat 5", s, c, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    logic        c;
    int          lat;
    int          t0;
    int          t1;
    t0 = $time;
    runOp(16'h0F0F, 16'h00F1, 1'b0, s, c, lat);
    runOp(16'h7FFF, 16'h7FFF, 1'b0, s, c, lat);
    t1 = $time;
    vecCount++;
    if (s !== 16'hFFFE || c !== 1'b0 || lat !== 5) begin
      errCount++;
      $display("FAIL b2b_result: got %h co %b lat %0d want FFFE co 0 lat 5", s, c, lat);
    end
    vecCount++;
    if ((t1 - t0) / 10 !== 12) begin
      errCount++;
      $display("FAIL b2b_interval: got %0d cycles for two ops want 12", (t1 - t0) / 10);
    end
  endtask

`ifdef ADD_SEQ_SUB_EN
  task automatic test_subtract;
    logic [15:0] s;
    logic        c;
    int          lat;
    runOp(16'h0007, 16'h0005, 1'b1, s, c, lat);
    vecCount++;
    if (s !== 16'h0002 || c !== 1'b1 || lat !== 5) begin
      errCount++;
      $display("FAIL sub_no_borrow: got %h co %b lat %0d want 0002 co 1 lat 5", s, c, lat);
    end
    runOp(16'h0005, 16'h0007, 1'b1, s, c, lat);
    vecCount++;
    if (s !== 16'hFFFE || c !== 1'b0) begin
      errCount++;
      $display("FAIL sub_borrow: got %h co %b want FFFE co 0", s, c);
    end
  endtask
`endif

  initial begin
    vecCount      = 0;
    errCount      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
`ifdef ADD_SEQ_SUB_EN
    bus.in_sub    = 1'b0;
`endif
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef ADD_SEQ_SUB_EN
    test_subtract();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
